// File: rtl/rotor2_inverse.sv
// Rotor-2 return path: undoes the rotor offset and applies the inverse wiring in a 2-stage valid/ready pipeline.
// Owns the rotor-2 position counter. Define ROTOR2_INV_CARRY_EN to add the registered carry_out to rotor 3.
`timescale 1ns/1ps
module rotor2_inverse #(
  parameter int unsigned RESET_POS = 0,
  parameter int unsigned NOTCH_POS = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_letter,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_letter,
  output logic       out_err,
  input  logic       step,
  input  logic       load,
  input  logic [4:0] load_pos,
  output logic [4:0] pos
`ifdef ROTOR2_INV_CARRY_EN
  ,
  output logic       carry_out
`endif
);

  logic       s1_valid;
  logic       s1_err;
  logic [4:0] s1_m;
  logic       s1_advance;
  logic [5:0] diff;
  logic [4:0] m_val;

  function automatic logic [4:0] inv(input logic [4:0] m);
    case (m)
      5'd1:  inv = 5'd6;   5'd2:  inv = 5'd13;  5'd3:  inv = 5'd18;
      5'd4:  inv = 5'd5;   5'd5:  inv = 5'd16;  5'd6:  inv = 5'd1;
      5'd7:  inv = 5'd21;  5'd8:  inv = 5'd17;  5'd9:  inv = 5'd15;
      5'd10: inv = 5'd14;  5'd11: inv = 5'd3;   5'd12: inv = 5'd22;
      5'd13: inv = 5'd19;  5'd14: inv = 5'd8;   5'd15: inv = 5'd2;
      5'd16: inv = 5'd10;  5'd17: inv = 5'd9;   5'd18: inv = 5'd23;
      5'd19: inv = 5'd20;  5'd20: inv = 5'd25;  5'd21: inv = 5'd4;
      5'd22: inv = 5'd26;  5'd23: inv = 5'd12;  5'd24: inv = 5'd11;
      5'd25: inv = 5'd24;  5'd26: inv = 5'd7;
      default: inv = 5'd0;
    endcase
  endfunction

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;

  // Offset removal mod 26; a negative difference wraps by adding 26.
  assign diff  = {1'b0, in_letter} - 6'd1 - {1'b0, pos};
  assign m_val = diff[5] ? 5'(diff + 6'd26) : diff[4:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_m     <= 5'd0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_m   <= m_val + 5'd1;
        s1_err <= (in_letter == 5'd0) || (in_letter > 5'd26);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_letter <= 5'd0;
      out_err    <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_letter <= s1_err ? 5'd0 : inv(s1_m);
        out_err    <= s1_err;
      end
    end
  end

  // Load wins over step; stepping is independent of pipeline backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= 5'(RESET_POS);
    end else if (load) begin
      pos <= (load_pos > 5'd25) ? 5'd0 : load_pos;
    end else if (step) begin
      pos <= (pos == 5'(NOTCH_POS)) ? 5'd0 : pos + 5'd1;
    end
  end

`ifdef ROTOR2_INV_CARRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_out <= 1'b0;
    end else begin
      carry_out <= step && !load && (pos == 5'(NOTCH_POS));
    end
  end
`endif

endmodule

// File: tb/tb_rotor2_inverse.sv
// Scoreboard bench for rotor2_inverse: expected letters come from inverting a forward-rotor model by search.
`timescale 1ns/1ps
module tb_rotor2_inverse;

  localparam int RESET_POS = 0;
  localparam int NOTCH_POS = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_letter = 5'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_letter;
  logic       out_err;
  logic       step = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_pos = 5'd0;
  logic [4:0] pos;
`ifdef ROTOR2_INV_CARRY_EN
  logic       carry_out;
`endif

  rotor2_inverse #(.RESET_POS(RESET_POS), .NOTCH_POS(NOTCH_POS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
    .out_valid(out_valid), .out_ready(out_ready), .out_letter(out_letter), .out_err(out_err),
    .step(step), .load(load), .load_pos(load_pos), .pos(pos)
`ifdef ROTOR2_INV_CARRY_EN
    , .carry_out(carry_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [4:0] letter;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   inv_tab[27];
  int   fwd_tab[27];
  int   model_pos = RESET_POS;
  bit   exp_carry = 0;
  bit   prev_hold = 0;
  logic [4:0] prev_letter = 5'd0;
  logic prev_err = 1'b0;
  bit   lat_chk = 0;
  int   acc_count = 0;

  // Forward rotor: wiring then rotation by p.
  function automatic int fwd(input int x, input int p);
    return ((fwd_tab[x] - 1 + p) % 26) + 1;
  endfunction

  // Inverse by exhaustive search over the forward map.
  function automatic exp_t ref_inv(input int y, input int p);
    exp_t r;
    r.letter = 5'd0;
    r.err    = 1'b1;
    r.cyc    = 0;
    if (y >= 1 && y <= 26) begin
      r.err = 1'b0;
      for (int x = 1; x <= 26; x++)
        if (fwd(x, p) == y) r.letter = 5'(x);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("pos", int'(pos), model_pos);
`ifdef ROTOR2_INV_CARRY_EN
      chk("carry_out", int'(carry_out), int'(exp_carry));
`endif
      if (out_valid) begin
        if (prev_hold) begin
          chk("hold_letter", int'(out_letter), int'(prev_letter));
          chk("hold_err", int'(out_err), int'(prev_err));
        end
        if (out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("out_letter", int'(out_letter), int'(e.letter));
            chk("out_err", int'(out_err), int'(e.err));
            if (lat_chk && !prev_hold) chk("latency", cyc - e.cyc, 2);
          end
        end
      end
      prev_hold   = out_valid && !out_ready;
      prev_letter = out_letter;
      prev_err    = out_err;
      if (in_valid && in_ready) begin
        exp_t e;
        e = ref_inv(int'(in_letter), model_pos);
        e.cyc = cyc;
        sbq.push_back(e);
        acc_count++;
      end
      exp_carry = step && !load && (model_pos == NOTCH_POS);
      if (load) model_pos = (load_pos > 5'd25) ? 0 : int'(load_pos);
      else if (step) model_pos = (model_pos == NOTCH_POS) ? 0 : model_pos + 1;
    end
  end

  task automatic send(input int l);
    bit ok;
    ok = 0;
    in_valid  = 1'b1;
    in_letter = 5'(l);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    step = 1'b0;
    load = 1'b0;
  endtask

  task automatic do_load(input int p);
    load = 1'b1;
    load_pos = 5'(p);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", int'(sbq.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int offs[3];
    int inv_init[26];
    int acc0;
    inv_init = '{6,13,18,5,16,1,21,17,15,14,3,22,19,8,2,10,9,23,20,25,4,26,12,11,24,7};
    for (int m = 1; m <= 26; m++) inv_tab[m] = inv_init[m-1];
    for (int m = 1; m <= 26; m++) fwd_tab[inv_tab[m]] = m;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_letter", int'(out_letter), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_pos", int'(pos), RESET_POS);
    chk("rst_in_ready", int'(in_ready), 1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    lat_chk = 1;
    send(6);
    drain();
    do_load(3);  send(9);
    do_load(25); send(5);
    do_load(0);  send(26);
    drain();

    offs = '{0, 13, 25};
    for (int k = 0; k < 3; k++) begin
      do_load(offs[k]);
      for (int x = 1; x <= 26; x++) send(fwd(x, offs[k]));
    end
    drain();

    do_load(25);
    step = 1'b1;
    send(5);
    repeat (2) @(posedge clk);
    #1;
    step = 1'b1; load = 1'b1; load_pos = 5'd7;
    @(posedge clk); #1;
    step = 1'b0; load = 1'b0;
    chk("step_load_pos", int'(pos), 7);
    send(0);
    send(27);
    drain();

    lat_chk = 0;
    out_ready = 1'b0;
    acc0 = acc_count;
    for (int n = 0; n < 6; n++) begin
      in_valid  = 1'b1;
      in_letter = 5'($urandom_range(1, 26));
      @(posedge clk); #1;
    end
    chk("bp_accepted", acc_count - acc0, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_letter = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 26));
      out_ready = ($urandom_range(0, 2) != 0);
      step      = ($urandom_range(0, 3) == 0);
      load      = ($urandom_range(0, 7) == 0);
      load_pos  = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; step = 1'b0; load = 1'b0;
    drain();

    lat_chk = 1;
    do_load(10);
    for (int n = 0; n < 3; n++) begin
      in_valid  = 1'b1;
      in_letter = 5'($urandom_range(1, 26));
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_pos", int'(pos), RESET_POS);
    sbq.delete();
    model_pos = RESET_POS;
    exp_carry = 0;
    prev_hold = 0;
    in_valid  = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(6);
    send(13);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotor2_inverse.md
Name: rotor2_inverse

Overview:
Return-path (reflector-to-keyboard) counterpart of the forward rotor-2 stage. It maps a letter arriving from the reflector side back through rotor 2's wiring in the inverse direction, compensating for the rotor's current rotational offset. The block owns the rotor-2 position counter: it steps on a carry from rotor 1 and presents its position to the forward stage. It has a 2-stage valid/ready pipeline and sits between the reflector-return stage and rotor1's inverse stage.

Parameters:
RESET_POS, 0, position loaded at reset (0..25).
NOTCH_POS, 25, position at which a step wraps to 0 and produces a carry.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  in_letter is valid.
in_ready  out  1  block can accept in_letter this cycle.
in_letter  in  5  letter from reflector side, encoded 1..26 (A..Z).
out_valid  out  1  out_letter is valid.
out_ready  in  1  downstream accepts out_letter.
out_letter  out  5  inverse-mapped letter, 1..26; 0 on error.
out_err  out  1  accompanies out_letter; high if the input letter was out of range.
step  in  1  one-cycle pulse: advance position by 1.
load  in  1  one-cycle pulse: position <= load_pos.
load_pos  in  5  new position, 0..25; values above 25 load as 0.
pos  out  5  current rotational offset, 0..25 (drives the forward stage's rotate input).

Behaviour:
- Reset is asynchronous and active-low: pos=RESET_POS, out_valid=0, out_letter=0, out_err=0, and both pipeline stages are empty. Reset mid-transfer discards in-flight letters.
- Handshake: a transfer occurs when valid and ready are both high at a clock edge. in_ready = !s1_valid || s1_advance, where s1_advance = !out_valid || out_ready. out_letter and out_err hold stable while out_valid=1 and out_ready=0.
- Latency is 2 cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 letter per cycle.
- Stage 1 (on acceptance):
  - Capture pos as it is before any same-cycle step or load.
  - Compute m = ((in_letter - 1 - pos) mod 26) + 1 using 6-bit arithmetic, adding 26 when the difference is negative. Result range is 1..26.
  - Set err = (in_letter == 0 || in_letter > 26).
- Stage 2: out_letter = INV[m], or 0 if err.
- INV table (m -> out): 1-6, 2-13, 3-18, 4-5, 5-16, 6-1, 7-21, 8-17, 9-15, 10-14, 11-3, 12-22, 13-19, 14-8, 15-2, 16-10, 17-9, 18-23, 19-20, 20-25, 21-4, 22-26, 23-12, 24-11, 25-24, 26-7.
- Invariant: if the forward stage maps x to y at offset p, this block maps y to x at offset p.
- Position counter:
  - load has priority over step.
  - On step: pos = (pos == NOTCH_POS) ? 0 : pos + 1.
  - step and load are never ignored because of backpressure.
  - A letter already in the pipeline uses the offset captured at its acceptance.

Optional Feature:
ROTOR2_INV_CARRY_EN: adds output port carry_out (1 bit), registered and reset to 0. carry_out pulses high for exactly one cycle after a step taken at pos == NOTCH_POS with no load in the same cycle; it drives rotor 3's step. Without the macro, the port and its logic are absent and the wrap is silent.

Test Plan:
- Reset with RESET_POS=0, pos=0, send letter 6 -> out_letter=1, out_err=0, out_valid exactly 2 cycles after acceptance.
- Load 3, send 9 -> out 1. Load 25, send 5 -> out 1. pos=0, send 26 -> out 7. Sweep all 26 letters at offsets 0, 13 and 25 against the forward model; all must round-trip.
- Hold out_ready=0 and stream letters -> at most 2 accepted, then in_ready=0; out_letter stays stable. Release -> letters drain in order with no loss or duplication.
- pos=25, assert step in the same cycle a letter is accepted -> that letter uses offset 25, pos becomes 0, and carry_out pulses once (with ROTOR2_INV_CARRY_EN). Assert step and load(7) together -> pos=7, no carry.
- Send letters 0 and 27 -> out_letter=0, out_err=1. Deassert rst_n mid-stream -> out_valid=0 and pos=RESET_POS immediately, without waiting for a clock edge.
